subtractor_32bit_pipe: RTL and testbench
========================================

// Module: subtractor_32bit_pipe
// PURPOSE
//  Pipelined 32-bit subtractor: D = A - B, with borrow-out and signed-overflow flags.
//  Two stages: the low half resolves in stage 1, the high half in stage 2.
//  Each half is a 16-bit carry-lookahead slice computing A + ~B + cin.
//  Valid/ready handshake on input and output; it sits beside adder_32bit in the ALU datapath.
// PARAMETERS
//  WIDTH  32  operand width; fixed, must equal 2*HALF
//  HALF   16  slice width per pipeline stage
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  A          in   [32:1]  minuend
//  B          in   [32:1]  subtrahend
//  in_valid   in   1       A/B valid
//  in_ready   out  1       stage 1 can accept
//  D          out  [32:1]  difference A-B mod 2^32
//  BORROW     out  1       1 when unsigned A < B (inverse of carry out)
//  OVF        out  1       signed overflow: A[32]!=B[32] && D[32]!=A[32]
//  out_valid  out  1       D/BORROW/OVF valid
//  out_ready  in   1       downstream accepts
// BEHAVIOUR
//  - Reset (async assert, sync release): both stage valids=0; D, BORROW, OVF, out_valid=0.
//    in_ready=1 once reset is released.
//  - Input transfer happens when in_valid & in_ready; output transfer when out_valid & out_ready.
//  - Stage 1 on accept registers the following:
//    - low half: D1[16:1] = A[16:1] + ~B[16:1] + 1
//    - c16 = carry out of the low half
//    - A[32:17] and B[32:17]
//  - Stage 2 computes the high half: A[32:17] + ~B[32:17] + c16, giving carry c32.
//  - Stage 2 registers these outputs:
//    - D = {high half, D1}
//    - BORROW = ~c32
//    - OVF = A[32]!=B[32] && D[32]!=A[32]
//  - Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1/cycle.
//  - Stage 2 loads when stage 1 is valid and (stage 2 is empty or out_ready).
//  - Stage 1 loads when stage 2 loads or stage 1 is empty.
//  - in_ready = ~s1_valid | s2_load. It is combinational from out_ready; there is no skid buffer.
//  - Stall: with out_ready=0 and both stages full, in_ready=0.
//    D, BORROW, OVF and out_valid hold stable until the output transfer.
//  - Simultaneous output transfer and input transfer: both stages advance in the same cycle, no bubble.
//  - in_valid=0 while stage 1 drains: s1_valid clears and a bubble propagates.
//    Outputs hold their last value while out_valid=0 (contents are don't-care to the consumer).
//  - Reset mid-operation drops all in-flight operations immediately. There is no partial output.
//  - Arithmetic is pure two's complement mod 2^32. A==B gives D=0, BORROW=0, OVF=0.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - constants WIDTH=32 and HALF=16
//    - typedef word_t [32:1] and half_t [16:1]
//  - One sub-module, cla16_addc:
//    - inputs: x[16:1], y[16:1], cin
//    - outputs: s[16:1], cout
//    - internally four 4-bit lookahead groups
//  - cla16_addc is instantiated twice, once per stage, with y driven by ~B.
//  - The top level holds only pipeline registers, handshake logic and the flag logic.
// TESTING
//  1. A=5, B=3, single op -> after 2 cycles D=0x00000002, BORROW=0, OVF=0, out_valid for 1 cycle.
//  2. A=0, B=1 -> D=0xFFFFFFFF, BORROW=1, OVF=0.
//     A=0x0001_0000, B=0x0000_0001 -> D=0x0000_FFFF (borrow crosses the stage boundary).
//  3. A=0x80000000, B=1 -> D=0x7FFFFFFF, OVF=1, BORROW=0.
//     A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, OVF=1, BORROW=1.
//  4. Back-to-back stream of 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready stays 1.
//  5. out_ready=0 with 4 ops offered -> 2 accepted, then in_ready=0 and outputs stable.
//     Release out_ready -> all 4 results emerge in order, none lost or duplicated.
//  6. Assert rst_n=0 with both stages full -> out_valid=0 and in_ready=0 immediately; after release no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath widths and word types
package alu_pkg;
   localparam int WIDTH = 32;
   localparam int HALF  = 16;

   typedef logic [WIDTH:1] word_t;
   typedef logic [HALF:1]  half_t;
endpackage

// File: rtl/cla16_addc.sv
// rtl/cla16_addc.sv - 16-bit carry-lookahead adder with carry in/out
module cla16_addc
   import alu_pkg::*;
(
   input  half_t x,
   input  half_t y,
   input  logic  cin,
   output half_t s,
   output logic  cout
);
   half_t       w_g;
   half_t       w_p;
   logic [3:0]  w_gg;
   logic [3:0]  w_gp;
   logic [17:1] w_c;

   always_comb begin
      w_g = x & y;
      w_p = x ^ y;
      for (int k = 0; k < 4; k++) begin
         w_gg[k] = w_g[4*k+4]
                 | (w_p[4*k+4] & w_g[4*k+3])
                 | (w_p[4*k+4] & w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+4] & w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1]);
         w_gp[k] = &w_p[4*k+4 -: 4];
      end

      // group carries come straight from the lookahead terms, not rippled
      w_c     = '0;
      w_c[1]  = cin;
      w_c[5]  = w_gg[0] | (w_gp[0] & cin);
      w_c[9]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
      w_c[13] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
              | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
      w_c[17] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
              | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
              | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

      for (int i = 1; i <= 16; i++) begin
         if ((i % 4) != 0) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
         end
      end

      s    = w_p ^ w_c[16:1];
      cout = w_c[17];
   end
endmodule

// File: rtl/subtractor_32bit_pipe.sv
// rtl/subtractor_32bit_pipe.sv - two-stage pipelined 32-bit subtractor with borrow/overflow
module subtractor_32bit_pipe
   import alu_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  word_t A,
   input  word_t B,
   input  logic  in_valid,
   output logic  in_ready,
   output word_t D,
   output logic  BORROW,
   output logic  OVF,
   output logic  out_valid,
   input  logic  out_ready
);
   logic  r_s1_valid;
   half_t r_d_lo;
   logic  r_c16;
   half_t r_a_hi;
   half_t r_b_hi;

   logic  r_out_valid;
   word_t r_d;
   logic  r_borrow;
   logic  r_ovf;

   half_t w_b_lo_n;
   half_t w_b_hi_n;
   half_t w_lo_sum;
   logic  w_lo_cout;
   half_t w_hi_sum;
   logic  w_c32;
   logic  w_s2_load;
   logic  w_s1_load;
   logic  w_in_fire;

   assign w_b_lo_n = ~B[HALF:1];
   assign w_b_hi_n = ~r_b_hi;

   cla16_addc u_cla_lo (
      .x    (A[HALF:1]),
      .y    (w_b_lo_n),
      .cin  (1'b1),
      .s    (w_lo_sum),
      .cout (w_lo_cout)
   );

   cla16_addc u_cla_hi (
      .x    (r_a_hi),
      .y    (w_b_hi_n),
      .cin  (r_c16),
      .s    (w_hi_sum),
      .cout (w_c32)
   );

   assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
   assign w_s1_load = w_s2_load | ~r_s1_valid;
   // gated by rst_n so upstream sees no capacity while reset is held
   assign in_ready  = rst_n & w_s1_load;
   assign w_in_fire = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_d_lo     <= '0;
         r_c16      <= 1'b0;
         r_a_hi     <= '0;
         r_b_hi     <= '0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_fire) begin
            r_d_lo <= w_lo_sum;
            r_c16  <= w_lo_cout;
            r_a_hi <= A[WIDTH:HALF+1];
            r_b_hi <= B[WIDTH:HALF+1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_d         <= '0;
         r_borrow    <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_d         <= {w_hi_sum, r_d_lo};
         r_borrow    <= ~w_c32;
         r_ovf       <= (r_a_hi[HALF] != r_b_hi[HALF]) && (w_hi_sum[HALF] != r_a_hi[HALF]);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign D         = r_d;
   assign BORROW    = r_borrow;
   assign OVF       = r_ovf;
   assign out_valid = r_out_valid;
endmodule

// File: tb/tb_subtractor_32bit_pipe.sv
// tb/tb_subtractor_32bit_pipe.sv - directed vector bench for subtractor_32bit_pipe
module tb_subtractor_32bit_pipe;
   import alu_pkg::*;

   typedef struct {
      word_t a;
      word_t b;
      word_t d;
      logic  borrow;
      logic  ovf;
   } vec_t;

   logic  clk;
   logic  rst_n;
   word_t A;
   word_t B;
   logic  in_valid;
   logic  in_ready;
   word_t D;
   logic  BORROW;
   logic  OVF;
   logic  out_valid;
   logic  out_ready;

   int    errors;
   int    checks;
   vec_t  tv[10];
   word_t got_q[$];

   subtractor_32bit_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .BORROW    (BORROW),
      .OVF       (OVF),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      int    idx;
      logic  fire_in;
      word_t held;

      errors = 0;
      checks = 0;
      tv[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
      tv[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tv[2] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
      tv[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
      tv[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
      tv[5] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
      tv[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tv[7] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
      tv[8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0};
      tv[9] = '{32'h0001_0000, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};

      rst_n     = 1'b0;
      A         = '0;
      B         = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk("rst_D", D, 32'h0);
      chk1("rst_BORROW", BORROW, 1'b0);
      chk1("rst_OVF", OVF, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk1("post_rst_in_ready", in_ready, 1'b1);

      // isolated ops: latency, values and one-cycle out_valid pulse
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         A = tv[i].a; B = tv[i].b; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         chk1("single_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         chk1("single_lat1_valid", out_valid, 1'b0);
         @(negedge clk);
         chk1("single_out_valid", out_valid, 1'b1);
         chk("single_D", D, tv[i].d);
         chk1("single_BORROW", BORROW, tv[i].borrow);
         chk1("single_OVF", OVF, tv[i].ovf);
         @(negedge clk);
         chk1("single_pulse_end", out_valid, 1'b0);
      end

      // back-to-back stream of 8, full throughput
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid  = (c < 8);
         if (c < 8) begin
            A = tv[c].a; B = tv[c].b;
         end
         @(negedge clk);
         if (c < 8) chk1("stream_in_ready", in_ready, 1'b1);
         if (c >= 2) begin
            chk1("stream_out_valid", out_valid, 1'b1);
            chk("stream_D", D, tv[c-2].d);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("stream_drained", out_valid, 1'b0);

      // stall: 4 offered with out_ready low, only 2 fit
      idx = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            A = tv[idx].a; B = tv[idx].b;
         end
         @(negedge clk);
         fire_in = in_valid & in_ready;
         @(posedge clk); #1;
         if (fire_in) idx++;
      end
      chk("stall_accepted", idx, 2);
      @(negedge clk);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      chk("stall_D", D, tv[0].d);
      held = D;
      repeat (2) @(negedge clk);
      chk("stall_D_stable", D, held);
      chk1("stall_valid_stable", out_valid, 1'b1);

      got_q.delete();
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            A = tv[idx].a; B = tv[idx].b;
         end
         @(negedge clk);
         fire_in = in_valid & in_ready;
         if (out_valid & out_ready) got_q.push_back(D);
         @(posedge clk); #1;
         if (fire_in) idx++;
      end
      in_valid = 1'b0;
      chk("release_accepted", idx, 4);
      chk("release_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size()) chk("release_order_D", got_q[i], tv[i].d);
      end

      // reset with both stages full
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         A = tv[6+c].a; B = tv[6+c].b; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk1("prefill_out_valid", out_valid, 1'b1);
      chk1("prefill_in_ready", in_ready, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk1("midrst_release_in_ready", in_ready, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk1("no_stale_out_valid", out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
